pipelined_barrel_shifter: RTL and testbench
===========================================

// Module: pipelined_barrel_shifter
// PURPOSE
//  Pipelined successor to the combinational right rotator.
//  - Rotates or shifts WIDTH-bit data left or right by a per-beat amount, in units of SHIFTBITS_PER_STEP bits.
//  - Modes: rotate, logical shift, arithmetic shift.
//  - Mux stages are registered every REG_EVERY stages, with valid/ready flow control and a sideband tag.
//  - Sits in datapaths needing alignment or normalisation at full clock rate.
// PARAMETERS
//  WIDTH              32  data width; WIDTH/SHIFTBITS_PER_STEP must be a power of two >= 2
//  SHIFTBITS_PER_STEP 1   granularity of one amount unit, in bits (8 = byte shifter)
//  REG_EVERY          1   mux stages between registers; >= 1
//  USERW              1   width of the sideband tag carried alongside data
//  Derived: STAGES = $clog2(WIDTH/SHIFTBITS_PER_STEP); AMTW = STAGES; LAT = ceil(STAGES/REG_EVERY), min 1
// PORTS
//  clk       in   1      clock
//  rstN      in   1      asynchronous active-low reset
//  flush     in   1      synchronous; drops all in-flight beats
//  inValid   in   1      input beat valid
//  inReady   out  1      input beat accepted when inValid && inReady
//  inData    in   WIDTH  data to shift
//  inAmount  in   AMTW   shift amount in steps (bits = inAmount*SHIFTBITS_PER_STEP)
//  inLeft    in   1      1 = left, 0 = right
//  inMode    in   2      00 rotate, 01 logical, 10 arithmetic, 11 = rotate
//  inUser    in   USERW  tag, returned unchanged with the result
//  outValid  out  1      result valid
//  outReady  in   1      result consumed when outValid && outReady
//  outData   out  WIDTH  shifted result
//  outUser   out  USERW  tag of this result
// BEHAVIOUR
//  - Reset (rstN=0, async): every stage valid=0, every data/tag register=0; outValid=0, outData=0, outUser=0.
//  - After reset release, inReady=1 (combinational).
//  - Mux stage i acts on amount bit i: shift by 2**i*SHIFTBITS_PER_STEP bits.
//  - Amount, direction and mode travel with the data through every register.
//  - Pipeline: LAT register slots, each with a valid bit.
//    - Slot k may load when !valid[k] || ready[k+1]; ready[LAT] = outReady.
//    - inReady = ready[0]. Bubbles collapse, so throughput is 1 beat/clk when outReady=1.
//  - Latency: accepted beat appears on outValid exactly LAT clks later if never stalled.
//  - Ordering: strict FIFO; no beat is dropped or duplicated under any outReady pattern.
//  - outValid && !outReady: outData/outUser hold stable until the handshake.
//  - Rotate: bits leaving one end re-enter at the other. Left rotate by n == right rotate by (STEPS-n).
//  - Logical: vacated bits are 0.
//  - Arithmetic: right fills with inData[WIDTH-1]; left is identical to logical left.
//  - inAmount=0: outData == inData in all modes and both directions.
//  - Max amount (all ones): rotates by STEPS-1 steps; shifts leave exactly SHIFTBITS_PER_STEP original bits.
//  - flush=1 at a clock edge:
//    - clears all valid bits; the beat presented that cycle is not accepted (inReady=0 while flush=1).
//    - outValid=0 on the following cycle.
//  - rstN asserted mid-stream: all beats are lost immediately; no partial result is ever presented.
//  - Data/tag registers load only on a slot load; gating them further is allowed, but must not change outputs.
// TESTING
//  T1 WIDTH=8,STEP=1,REG_EVERY=1 (LAT=3): 0x81 amt=1 right rotate -> outData=0xC0 exactly 3 clks after accept.
//  T2 Same cfg, back-to-back:
//     - 0x81 amt=3 left logical -> 0x08
//     - 0x80 amt=2 right arith  -> 0xE0
//     - 0x80 amt=2 right logical -> 0x20
//     - results on consecutive clks, tags 1,2,3 in order.
//  T3 WIDTH=32,STEP=8,REG_EVERY=2 (LAT=1): 0x11223344 amt=1 right rotate -> 0x44112233; left rotate -> 0x22334411.
//  T4 Backpressure:
//     - stream 6 beats with outReady=0 for 5 clks; inReady falls after 3 accepted beats.
//     - outData stays stable while stalled; all 6 results delivered in order once outReady=1.
//  T5 Random outValid/outReady and inValid toggling over 10k beats:
//     - scoreboard vs reference model, zero mismatches/losses.
//     - amount 0 and max amount covered in every mode.
//  T6 flush with 2 beats in flight -> outValid=0 next clk, neither result ever appears.
//     rstN pulse mid-stream -> outputs 0 asynchronously; clean restart afterwards.

Source files
------------

// File: rtl/pipelined_barrel_shifter_if.sv
// Beat-level valid/ready bundle for the pipelined barrel shifter: input beat plus result beat.
// master drives beats in and consumes results; slave is the shifter itself.
interface pipelined_barrel_shifter_if #(
    parameter int WIDTH              = 32,
    parameter int SHIFTBITS_PER_STEP = 1,
    parameter int USERW              = 1
);
    localparam int AMTW = $clog2(WIDTH / SHIFTBITS_PER_STEP);

    logic             inValid;
    logic             inReady;
    logic [WIDTH-1:0] inData;
    logic [AMTW-1:0]  inAmount;
    logic             inLeft;
    logic [1:0]       inMode;
    logic [USERW-1:0] inUser;
    logic             outValid;
    logic             outReady;
    logic [WIDTH-1:0] outData;
    logic [USERW-1:0] outUser;

    modport master (
        output inValid, inData, inAmount, inLeft, inMode, inUser, outReady,
        input  inReady, outValid, outData, outUser
    );

    modport slave (
        input  inValid, inData, inAmount, inLeft, inMode, inUser, outReady,
        output inReady, outValid, outData, outUser
    );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// Rotate / logical / arithmetic shifter, log2 mux stages cut into LAT registered slots.
// Latency LAT clks; per-slot valid with collapsing bubbles, inReady = slot 0 may load && !flush.
module pipelined_barrel_shifter #(
    parameter int WIDTH              = 32,
    parameter int SHIFTBITS_PER_STEP = 1,
    parameter int REG_EVERY          = 1,
    parameter int USERW              = 1
) (
    input  logic                         clk,
    input  logic                         rstN,
    input  logic                         flush,
    pipelined_barrel_shifter_if.slave    bus
);
    localparam int STEPS   = WIDTH / SHIFTBITS_PER_STEP;
    localparam int STAGES  = $clog2(STEPS);
    localparam int AMTW    = STAGES;
    localparam int LAT_RAW = (STAGES + REG_EVERY - 1) / REG_EVERY;
    localparam int LAT     = (LAT_RAW < 1) ? 1 : LAT_RAW;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [AMTW-1:0]  amt;
        logic             left;
        logic [1:0]       mode;
        logic [USERW-1:0] user;
    } beat_t;

    beat_t            slot_q   [LAT];
    beat_t            slot_d   [LAT];
    beat_t            src      [LAT];
    logic [LAT-1:0]   vld_q;
    logic [LAT-1:0]   src_vld;
    logic [LAT-1:0]   rdy;

    // One mux stage. Arithmetic right by 2^i applied repeatedly keeps the sign in the MSB,
    // so chaining stages gives the same fill as one wide arithmetic shift.
    function automatic logic [WIDTH-1:0] stage_fn(input logic [WIDTH-1:0] d, input int sh,
                                                  input logic left, input logic [1:0] mode);
        logic [WIDTH-1:0] r;
        if (left) begin
            if (mode == 2'b01 || mode == 2'b10) r = d << sh;
            else                                 r = (d << sh) | (d >> (WIDTH - sh));
        end else begin
            if (mode == 2'b01)      r = d >> sh;
            else if (mode == 2'b10) r = $unsigned($signed(d) >>> sh);
            else                    r = (d >> sh) | (d << (WIDTH - sh));
        end
        return r;
    endfunction

    always_comb begin
        src[0].data = bus.inData;
        src[0].amt  = bus.inAmount;
        src[0].left = bus.inLeft;
        src[0].mode = bus.inMode;
        src[0].user = bus.inUser;
        src_vld[0]  = bus.inValid;
        for (int k = 1; k < LAT; k++) begin
            src[k]     = slot_q[k-1];
            src_vld[k] = vld_q[k-1];
        end
        for (int k = 0; k < LAT; k++) begin
            slot_d[k] = src[k];
            for (int s = 0; s < STAGES; s++) begin
                if ((s / REG_EVERY) == k && src[k].amt[s])
                    slot_d[k].data = stage_fn(slot_d[k].data, (1 << s) * SHIFTBITS_PER_STEP,
                                              src[k].left, src[k].mode);
            end
        end
        // Slot k can take a beat if any slot at or after it has a hole, or the sink is taking one.
        for (int k = 0; k < LAT; k++) begin
            rdy[k] = bus.outReady;
            for (int j = k; j < LAT; j++) begin
                if (!vld_q[j]) rdy[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            vld_q <= '0;
            for (int k = 0; k < LAT; k++) slot_q[k] <= '0;
        end else if (flush) begin
            vld_q <= '0;
        end else begin
            for (int k = 0; k < LAT; k++) begin
                if (rdy[k]) begin
                    vld_q[k] <= src_vld[k];
                    if (src_vld[k]) slot_q[k] <= slot_d[k];
                end
            end
        end
    end

    assign bus.inReady  = rdy[0] && !flush;
    assign bus.outValid = vld_q[LAT-1];
    assign bus.outData  = slot_q[LAT-1].data;
    assign bus.outUser  = slot_q[LAT-1].user;

    logic unused_tail;
    assign unused_tail = ^{slot_q[LAT-1].amt, slot_q[LAT-1].left, slot_q[LAT-1].mode};
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Bench: 8-bit/LAT=3 shifter under directed, backpressure, random, flush and reset traffic,
// plus a 32-bit byte shifter (REG_EVERY=2, LAT=1) streamed against the same reference model.
module tb_pipelined_barrel_shifter;
    localparam int LAT_A = 3;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    logic flush = 1'b0;
    logic flush_b = 1'b0;
    int   cyc = 0;
    int   nvec = 0;
    int   nerr = 0;
    int   acc_cnt = 0;
    bit   chk_lat = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    pipelined_barrel_shifter_if #(.WIDTH(8), .SHIFTBITS_PER_STEP(1), .USERW(4)) bus_a ();
    pipelined_barrel_shifter_if #(.WIDTH(32), .SHIFTBITS_PER_STEP(8), .USERW(4)) bus_b ();

    pipelined_barrel_shifter #(.WIDTH(8), .SHIFTBITS_PER_STEP(1), .REG_EVERY(1), .USERW(4)) dut_a (
        .clk(clk), .rstN(rstN), .flush(flush), .bus(bus_a));
    pipelined_barrel_shifter #(.WIDTH(32), .SHIFTBITS_PER_STEP(8), .REG_EVERY(2), .USERW(4)) dut_b (
        .clk(clk), .rstN(rstN), .flush(flush_b), .bus(bus_b));

    task automatic chk(input bit ok, input string nm, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (!ok) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Bit-by-bit definition: output bit i takes the source bit n positions away, with fill by mode.
    function automatic logic [31:0] model(input logic [31:0] d, input int amt, input bit left,
                                          input logic [1:0] mode, input int w, input int sb);
        logic [31:0] r = '0;
        int n = amt * sb;
        for (int i = 0; i < w; i++) begin
            int src;
            if (!left) begin
                src = i + n;
                if (src < w)          r[i] = d[src];
                else if (mode == 2'b01) r[i] = 1'b0;
                else if (mode == 2'b10) r[i] = d[w-1];
                else                  r[i] = d[src-w];
            end else begin
                src = i - n;
                if (src >= 0)                        r[i] = d[src];
                else if (mode == 2'b01 || mode == 2'b10) r[i] = 1'b0;
                else                                 r[i] = d[src+w];
            end
        end
        return r;
    endfunction

    typedef struct { logic [31:0] d; logic [3:0] u; int acc; } exp_t;
    exp_t q[$];
    bit          stall_prev = 1'b0;
    bit          idle_chk = 1'b0;
    logic [7:0]  prev_d;
    logic [3:0]  prev_u;

    // Scoreboard for dut_a: every negedge, check outputs, then record what the next edge accepts.
    always @(negedge clk) begin
        if (!rstN) begin
            q.delete();
            stall_prev = 1'b0;
            idle_chk = 1'b0;
        end else begin
            if (idle_chk) begin
                chk(!bus_a.outValid, "flush_outvalid_low", 32'(bus_a.outValid), 0);
                idle_chk = 1'b0;
            end
            if (stall_prev)
                chk(bus_a.outValid && bus_a.outData == prev_d && bus_a.outUser == prev_u,
                    "stall_hold", {bus_a.outUser, bus_a.outData}, {prev_u, prev_d});
            if (bus_a.outValid) begin
                if (q.size() == 0) begin
                    chk(1'b0, "spurious_result", {bus_a.outUser, bus_a.outData}, 0);
                end else begin
                    chk({bus_a.outUser, 24'd0, bus_a.outData} == {q[0].u, q[0].d},
                        "result", {bus_a.outUser, bus_a.outData}, {q[0].u, q[0].d[7:0]});
                    if (chk_lat && !stall_prev)
                        chk(cyc - q[0].acc == LAT_A, "latency", cyc - q[0].acc, LAT_A);
                    if (bus_a.outReady && !flush) void'(q.pop_front());
                end
            end
            stall_prev = bus_a.outValid && !bus_a.outReady && !flush;
            prev_d = bus_a.outData;
            prev_u = bus_a.outUser;
            if (flush) begin
                chk(!bus_a.inReady, "flush_inready_low", 32'(bus_a.inReady), 0);
                q.delete();
                idle_chk = 1'b1;
            end else if (bus_a.inValid && bus_a.inReady) begin
                q.push_back('{d: model(32'(bus_a.inData), int'(bus_a.inAmount), bus_a.inLeft,
                                       bus_a.inMode, 8, 1),
                              u: bus_a.inUser, acc: cyc});
                acc_cnt++;
            end
        end
    end

    task automatic set_a(input logic [7:0] d, input logic [2:0] a, input bit l,
                         input logic [1:0] m, input logic [3:0] u);
        bus_a.inData = d; bus_a.inAmount = a; bus_a.inLeft = l; bus_a.inMode = m; bus_a.inUser = u;
    endtask

    task automatic set_rand_a(input logic [3:0] u);
        int r = $urandom_range(0, 3);
        logic [2:0] a = (r == 0) ? 3'd0 : (r == 1) ? 3'd7 : 3'($urandom_range(0, 7));
        set_a(8'($urandom), a, 1'($urandom), 2'($urandom), u);
    endtask

    // Called at posedge+1; returns at posedge+1 after the edge that accepted the beat.
    task automatic send_a(input logic [7:0] d, input logic [2:0] a, input bit l,
                          input logic [1:0] m, input logic [3:0] u);
        set_a(d, a, l, m, u);
        bus_a.inValid = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (bus_a.inReady) begin
                @(posedge clk); #1;
                bus_a.inValid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        chk(1'b0, "send_timeout", 0, 1);
        bus_a.inValid = 1'b0;
    endtask

    task automatic wait_valid_a(input string nm);
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (bus_a.outValid) return;
        end
        chk(1'b0, nm, 0, 1);
    endtask

    task automatic drain_a(input string nm);
        bus_a.inValid = 1'b0;
        bus_a.outReady = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk(q.size() == 0, nm, q.size(), 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        logic [31:0] exp_b;
        logic [3:0]  exp_ub;
        bus_a.inValid = 1'b0; bus_a.outReady = 1'b1; set_a(8'h0, 3'd0, 1'b0, 2'b00, 4'h0);
        bus_b.inValid = 1'b0; bus_b.outReady = 1'b1;
        bus_b.inData = '0; bus_b.inAmount = '0; bus_b.inLeft = 1'b0; bus_b.inMode = 2'b00; bus_b.inUser = '0;

        // Model pinned to hand-worked values.
        chk(model(32'h81, 1, 0, 2'b00, 8, 1) == 32'hC0, "model_rotr", model(32'h81, 1, 0, 2'b00, 8, 1), 32'hC0);
        chk(model(32'h81, 3, 1, 2'b01, 8, 1) == 32'h08, "model_lsl", model(32'h81, 3, 1, 2'b01, 8, 1), 32'h08);
        chk(model(32'h80, 2, 0, 2'b10, 8, 1) == 32'hE0, "model_asr", model(32'h80, 2, 0, 2'b10, 8, 1), 32'hE0);
        chk(model(32'h80, 2, 0, 2'b01, 8, 1) == 32'h20, "model_lsr", model(32'h80, 2, 0, 2'b01, 8, 1), 32'h20);
        chk(model(32'hFF, 7, 0, 2'b01, 8, 1) == 32'h01, "model_max_lsr", model(32'hFF, 7, 0, 2'b01, 8, 1), 32'h01);
        chk(model(32'h11223344, 1, 0, 2'b11, 32, 8) == 32'h44112233, "model_byte_rotr",
            model(32'h11223344, 1, 0, 2'b11, 32, 8), 32'h44112233);

        // Reset state.
        #12;
        chk(!bus_a.outValid && bus_a.outData == 8'h0 && bus_a.outUser == 4'h0, "reset_outputs",
            {bus_a.outValid, bus_a.outUser, bus_a.outData}, 0);
        @(posedge clk); #1; rstN = 1'b1;
        @(negedge clk);
        chk(bus_a.inReady, "inready_after_reset", 32'(bus_a.inReady), 1);
        @(posedge clk); #1;

        // T1 / T2: directed values, exact latency, back-to-back order.
        chk_lat = 1'b1;
        send_a(8'h81, 3'd1, 1'b0, 2'b00, 4'd1);
        wait_valid_a("t1_timeout");
        chk(bus_a.outData == 8'hC0, "t1_rotr", 32'(bus_a.outData), 32'hC0);
        @(posedge clk); #1;
        send_a(8'h81, 3'd3, 1'b1, 2'b01, 4'd1);
        send_a(8'h80, 3'd2, 1'b0, 2'b10, 4'd2);
        send_a(8'h80, 3'd2, 1'b0, 2'b01, 4'd3);
        wait_valid_a("t2_timeout");
        chk({bus_a.outUser, bus_a.outData} == 12'h108, "t2_beat1", {bus_a.outUser, bus_a.outData}, 32'h108);
        @(negedge clk);
        chk(bus_a.outValid && {bus_a.outUser, bus_a.outData} == 12'h2E0, "t2_beat2",
            {bus_a.outValid, bus_a.outUser, bus_a.outData}, 32'h12E0);
        @(negedge clk);
        chk(bus_a.outValid && {bus_a.outUser, bus_a.outData} == 12'h320, "t2_beat3",
            {bus_a.outValid, bus_a.outUser, bus_a.outData}, 32'h1320);
        @(posedge clk); #1;
        chk_lat = 1'b0;
        drain_a("t2_drain");

        // T3 plus streaming on the byte shifter: result of cycle i-1 visible at negedge of cycle i.
        exp_b = '0; exp_ub = '0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            bus_b.inValid = 1'b1;
            if (i < 2) begin
                bus_b.inData = 32'h11223344; bus_b.inAmount = 2'd1; bus_b.inLeft = 1'(i); bus_b.inMode = 2'b00;
            end else begin
                bus_b.inData = $urandom; bus_b.inAmount = 2'($urandom); bus_b.inLeft = 1'($urandom);
                bus_b.inMode = 2'($urandom);
            end
            bus_b.inUser = 4'(i);
            @(negedge clk);
            if (i == 1) chk(bus_b.outData == 32'h44112233, "t3_rotr", bus_b.outData, 32'h44112233);
            if (i == 2) chk(bus_b.outData == 32'h22334411, "t3_rotl", bus_b.outData, 32'h22334411);
            if (i > 0)
                chk(bus_b.outValid && bus_b.outData == exp_b && bus_b.outUser == exp_ub, "b_stream",
                    bus_b.outData, exp_b);
            exp_b = model(bus_b.inData, int'(bus_b.inAmount), bus_b.inLeft, bus_b.inMode, 32, 8);
            exp_ub = bus_b.inUser;
        end
        @(posedge clk); #1; bus_b.inValid = 1'b0;

        // T4: backpressure fills the three slots, then releases.
        bus_a.outReady = 1'b0;
        b = 0;
        for (int c = 0; c < 5; c++) begin
            set_rand_a(4'(b)); bus_a.inValid = 1'b1;
            @(negedge clk);
            if (bus_a.inReady) b++;
            @(posedge clk); #1;
        end
        chk(b == 3, "t4_accepted_while_stalled", b, 3);
        chk(!bus_a.inReady, "t4_inready_low", 32'(bus_a.inReady), 0);
        bus_a.outReady = 1'b1;
        for (int c = 0; c < 50 && b < 6; c++) begin
            set_rand_a(4'(b)); bus_a.inValid = 1'b1;
            @(negedge clk);
            if (bus_a.inReady) b++;
            @(posedge clk); #1;
        end
        drain_a("t4_drain");

        // T5: random traffic on both sides.
        acc_cnt = 0;
        for (int c = 0; c < 60000 && acc_cnt < 10000; c++) begin
            bus_a.inValid = ($urandom_range(0, 9) < 7);
            bus_a.outReady = ($urandom_range(0, 9) < 6);
            set_rand_a(4'($urandom));
            @(posedge clk); #1;
        end
        chk(acc_cnt >= 10000, "t5_beats_accepted", acc_cnt, 10000);
        drain_a("t5_drain");

        // T6a: flush with two beats in flight.
        bus_a.outReady = 1'b0;
        send_a(8'h5A, 3'd1, 1'b1, 2'b00, 4'hA);
        send_a(8'hA5, 3'd2, 1'b0, 2'b10, 4'hB);
        flush = 1'b1; bus_a.inValid = 1'b1; set_a(8'h33, 3'd0, 1'b0, 2'b00, 4'hC);
        @(posedge clk); #1;
        flush = 1'b0; bus_a.inValid = 1'b0; bus_a.outReady = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        // T6b: asynchronous reset mid-stream, then clean restart.
        for (int c = 0; c < 8; c++) begin
            bus_a.inValid = 1'b1;
            set_a(8'($urandom_range(1, 255)), 3'd0, 1'b0, 2'b00, 4'($urandom_range(1, 15)));
            @(posedge clk); #1;
        end
        @(posedge clk); #3;
        rstN = 1'b0;
        #1;
        chk(!bus_a.outValid && bus_a.outData == 8'h0 && bus_a.outUser == 4'h0, "async_reset_outputs",
            {bus_a.outValid, bus_a.outUser, bus_a.outData}, 0);
        bus_a.inValid = 1'b0;
        @(posedge clk); #2;
        rstN = 1'b1;
        @(posedge clk); #1;
        chk_lat = 1'b1;
        send_a(8'hF0, 3'd4, 1'b0, 2'b10, 4'd7);
        send_a(8'h0F, 3'd7, 1'b1, 2'b11, 4'd8);
        wait_valid_a("restart_timeout");
        chk({bus_a.outUser, bus_a.outData} == 12'h7FF, "restart_beat1", {bus_a.outUser, bus_a.outData}, 32'h7FF);
        @(posedge clk); #1;
        chk_lat = 1'b0;
        drain_a("restart_drain");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
